// File: rtl/trace_pkg.sv
// Shared definitions for the trace dispatcher: command codes, FSM states,
// the buffered record layout and the filtered-code predicate.
package trace_pkg;

  localparam int TRACE_AW = 32;

  localparam logic [3:0] CMD_RD_DATA = 4'd0;
  localparam logic [3:0] CMD_WR_DATA = 4'd1;
  localparam logic [3:0] CMD_RD_INST = 4'd2;
  localparam logic [3:0] CMD_INVAL   = 4'd3;
  localparam logic [3:0] CMD_SNOOP   = 4'd4;
  localparam logic [3:0] CMD_CLEAR   = 4'd8;
  localparam logic [3:0] CMD_PRINT   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Record as held in the FIFO, most significant field first.
  typedef struct packed {
    logic                last;
    logic [3:0]          n;
    logic [TRACE_AW-1:0] add;
  } trace_rec_t;

  // Codes the caches do not understand: 5, 6, 7 and 10..15.
  function automatic logic is_filtered(input logic [3:0] code);
    return (code == 4'd5) || (code == 4'd6) || (code == 4'd7) || (code >= 4'd10);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with one extra pointer bit so that full and empty are told
// apart by comparing the pointer MSBs. DEPTH must be a power of two, >= 2.
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic         clk,
  input  logic         clear_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push_s;
  logic          do_pop_s;

  assign full_o    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign rdata_o   = mem_q[rd_ptr_q[PW-2:0]];

  // Pointer advance; the extra MSB toggles on every wrap.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q[PW-2:0]] <= wdata_i;
  end

endmodule

// File: rtl/trace_dispatch.sv
// Trace dispatcher: buffers trace records and hands them one at a time to
// the L1 caches, pulsing clear_stats on command 8 and done after the record
// tagged last has been consumed.
// Optional build macro TRACE_FILTER_EN: drops unsupported codes at push and
// counts them on bad_count.
module trace_dispatch
  import trace_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = TRACE_AW
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          rec_valid,
  output logic          rec_ready,
  input  logic [3:0]    rec_n,
  input  logic [AW-1:0] rec_add,
  input  logic          rec_last,
  output logic [3:0]    n,
  output logic [AW-1:0] add_in,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          clear_stats,
  output logic          done,
`ifdef TRACE_FILTER_EN
  output logic [15:0]   bad_count,
`endif
  output logic [31:0]   disp_count
);

  localparam int RW = AW + 5;

  state_t        state_q, state_d;
  logic          fifo_full_s, fifo_empty_s;
  logic [RW-1:0] fifo_rdata_s;
  logic          head_last_s;
  logic [3:0]    head_n_s;
  logic [AW-1:0] head_add_s;
  logic          push_fire_s, store_s, pop_s, consume_s;

  logic [3:0]    n_q;
  logic [AW-1:0] add_q;
  logic          out_last_q;
  logic          cmd_valid_q;
  logic          clear_stats_q;
  logic          done_q;
  logic [31:0]   disp_count_q;

  assign rec_ready   = !fifo_full_s && ((state_q == ST_IDLE) || (state_q == ST_RUN));
  assign push_fire_s = rec_valid && rec_ready;
  assign pop_s       = !fifo_empty_s && (!cmd_valid_q || cmd_ready);
  assign consume_s   = cmd_valid_q && cmd_ready;
  assign {head_last_s, head_n_s, head_add_s} = fifo_rdata_s;

`ifdef TRACE_FILTER_EN
  logic        drop_s;
  logic        last_drop_q, last_drop_d;
  logic [15:0] bad_count_q;

  assign drop_s    = push_fire_s && is_filtered(rec_n);
  assign store_s   = push_fire_s && !drop_s;
  assign bad_count = bad_count_q;

  // Dropped-record bookkeeping: saturating count and a pending dropped last.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      bad_count_q <= 16'd0;
      last_drop_q <= 1'b0;
    end else begin
      last_drop_q <= last_drop_d;
      if (drop_s && (bad_count_q != 16'hFFFF)) bad_count_q <= bad_count_q + 16'd1;
    end
  end
`else
  assign store_s = push_fire_s;
`endif

  trace_fifo #(.DEPTH(DEPTH), .W(RW)) u_fifo (
    .clk     (clk),
    .clear_n (clear_n),
    .push_i  (store_s),
    .wdata_i ({rec_last, rec_n, rec_add}),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Trace-level state register.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: a last-tagged push closes the intake, its consume ends the trace.
  always_comb begin
    state_d = state_q;
`ifdef TRACE_FILTER_EN
    last_drop_d = last_drop_q;
`endif
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (push_fire_s && rec_last) begin
`ifdef TRACE_FILTER_EN
          if (drop_s && fifo_empty_s && !cmd_valid_q) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_DRAIN;
            last_drop_d = drop_s;
          end
`else
          state_d = ST_DRAIN;
`endif
        end else if (push_fire_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
`ifdef TRACE_FILTER_EN
        if (last_drop_q) begin
          if (fifo_empty_s && !cmd_valid_q) begin
            state_d     = ST_DONE;
            last_drop_d = 1'b0;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (consume_s && out_last_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
`else
        if (consume_s && out_last_q) state_d = ST_DONE;
        else                         state_d = ST_DRAIN;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command output register, dispatch counter and one-cycle pulses.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      n_q           <= 4'd0;
      add_q         <= {AW{1'b0}};
      out_last_q    <= 1'b0;
      cmd_valid_q   <= 1'b0;
      clear_stats_q <= 1'b0;
      done_q        <= 1'b0;
      disp_count_q  <= 32'd0;
    end else begin
      if (pop_s) begin
        n_q         <= head_n_s;
        add_q       <= head_add_s;
        out_last_q  <= head_last_s;
        cmd_valid_q <= 1'b1;
      end else if (consume_s) begin
        cmd_valid_q <= 1'b0;
      end
      clear_stats_q <= consume_s && (n_q == CMD_CLEAR);
      done_q        <= (state_d == ST_DONE);
      if (consume_s) disp_count_q <= disp_count_q + 32'd1;
    end
  end

  assign n           = n_q;
  assign add_in      = add_q;
  assign cmd_valid   = cmd_valid_q;
  assign clear_stats = clear_stats_q;
  assign done        = done_q;
  assign disp_count  = disp_count_q;

endmodule
